// File: rtl/triangle_scan_pkg.sv
// triangle_scan_pkg: coordinate width, screen defaults and scan FSM states shared
// by the triangle scan, inside-test and raster stages.
`timescale 1ns/1ps
`default_nettype none

package triangle_scan_pkg;

   localparam int CW           = 12;
   localparam int SCREEN_W_DEF = 40;
   localparam int SCREEN_H_DEF = 50;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/triangle_scan_bbox3.sv
// bbox3: combinational min/max of three unsigned coordinates, max clamped to LIMIT,
// with an empty flag when even the minimum lies beyond LIMIT.
`timescale 1ns/1ps
`default_nettype none

module bbox3
   import triangle_scan_pkg::*;
#(
   parameter int W     = CW,
   parameter int LIMIT = SCREEN_W_DEF - 1
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_min,
   output logic [W-1:0] o_max,
   output logic         o_empty
);

   localparam logic [W-1:0] c_lim = W'(LIMIT);

   logic [W-1:0] w_ab_min;
   logic [W-1:0] w_ab_max;
   logic [W-1:0] w_max_raw;

   always_comb begin
      w_ab_min  = (i_a < i_b) ? i_a : i_b;
      w_ab_max  = (i_a > i_b) ? i_a : i_b;
      o_min     = (w_ab_min < i_c) ? w_ab_min : i_c;
      w_max_raw = (w_ab_max > i_c) ? w_ab_max : i_c;
      o_max     = (w_max_raw > c_lim) ? c_lim : w_max_raw;
      o_empty   = (o_min > c_lim);
   end

endmodule

`default_nettype wire

// File: rtl/triangle_scan.sv
// triangle_scan: latches a triangle, computes its screen-clamped bounding box and
// streams every box pixel row-major over a valid/ready point interface.
`timescale 1ns/1ps
`default_nettype none

module triangle_scan #(
   parameter int SCREEN_W = triangle_scan_pkg::SCREEN_W_DEF,
   parameter int SCREEN_H = triangle_scan_pkg::SCREEN_H_DEF,
   parameter int CW       = triangle_scan_pkg::CW
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          tri_valid,
   output logic          tri_ready,
   input  logic [CW-1:0] Ponto1X,
   input  logic [CW-1:0] Ponto1Y,
   input  logic [CW-1:0] Ponto2X,
   input  logic [CW-1:0] Ponto2Y,
   input  logic [CW-1:0] Ponto3X,
   input  logic [CW-1:0] Ponto3Y,
   output logic [CW-1:0] V1X,
   output logic [CW-1:0] V1Y,
   output logic [CW-1:0] V2X,
   output logic [CW-1:0] V2Y,
   output logic [CW-1:0] V3X,
   output logic [CW-1:0] V3Y,
   output logic          pt_valid,
   input  logic          pt_ready,
   output logic [CW-1:0] pt_x,
   output logic [CW-1:0] pt_y,
   output logic          pt_last,
   output logic          tri_done
);

   import triangle_scan_pkg::*;

   localparam logic [CW-1:0] c_one = CW'(1);

   state_t r_state;
   state_t w_next;

   logic [CW-1:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
   logic [CW-1:0] r_xmin, r_xmax, r_ymax;
   logic [CW-1:0] r_pt_x, r_pt_y;

   logic [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
   logic          w_xempty, w_yempty, w_empty;
   logic          w_accept, w_hs, w_at_last;

   // Box is derived from the latched vertices, so it is valid throughout SETUP.
   bbox3 #(.W(CW), .LIMIT(SCREEN_W - 1)) u_bbox_x (
      .i_a     (r_v1x),
      .i_b     (r_v2x),
      .i_c     (r_v3x),
      .o_min   (w_xmin),
      .o_max   (w_xmax),
      .o_empty (w_xempty)
   );

   bbox3 #(.W(CW), .LIMIT(SCREEN_H - 1)) u_bbox_y (
      .i_a     (r_v1y),
      .i_b     (r_v2y),
      .i_c     (r_v3y),
      .o_min   (w_ymin),
      .o_max   (w_ymax),
      .o_empty (w_yempty)
   );

   assign w_empty   = w_xempty || w_yempty;
   assign w_accept  = tri_valid && (r_state == ST_IDLE);
   assign w_hs      = (r_state == ST_SCAN) && pt_ready;
   assign w_at_last = (r_pt_x == r_xmax) && (r_pt_y == r_ymax);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      tri_ready = 1'b0;
      pt_valid  = 1'b0;
      pt_last   = 1'b0;
      tri_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            tri_ready = 1'b1;
            if (tri_valid) w_next = ST_SETUP;
         end
         ST_SETUP: begin
            w_next = w_empty ? ST_DONE : ST_SCAN;
         end
         ST_SCAN: begin
            pt_valid = 1'b1;
            pt_last  = w_at_last;
            if (pt_ready && w_at_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            tri_done = 1'b1;
            w_next   = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_v1x  <= '0;
         r_v1y  <= '0;
         r_v2x  <= '0;
         r_v2y  <= '0;
         r_v3x  <= '0;
         r_v3y  <= '0;
         r_xmin <= '0;
         r_xmax <= '0;
         r_ymax <= '0;
         r_pt_x <= '0;
         r_pt_y <= '0;
      end else begin
         if (w_accept) begin
            r_v1x <= Ponto1X;
            r_v1y <= Ponto1Y;
            r_v2x <= Ponto2X;
            r_v2y <= Ponto2Y;
            r_v3x <= Ponto3X;
            r_v3y <= Ponto3Y;
         end
         if (r_state == ST_SETUP) begin
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymax <= w_ymax;
            r_pt_x <= w_xmin;
            r_pt_y <= w_ymin;
         end else if (w_hs && !w_at_last) begin
            // Row wrap: return to the left edge of the box on the next line.
            if (r_pt_x == r_xmax) begin
               r_pt_x <= r_xmin;
               r_pt_y <= r_pt_y + c_one;
            end else begin
               r_pt_x <= r_pt_x + c_one;
            end
         end
      end
   end

   assign V1X  = r_v1x;
   assign V1Y  = r_v1y;
   assign V2X  = r_v2x;
   assign V2Y  = r_v2y;
   assign V3X  = r_v3x;
   assign V3Y  = r_v3y;
   assign pt_x = r_pt_x;
   assign pt_y = r_pt_y;

endmodule

`default_nettype wire

// File: tb/tb_triangle_scan.sv
// tb_triangle_scan: vector table plus randomized triangles checked against a
// bounding-box point-list model.
`timescale 1ns/1ps
`default_nettype none

module tb_triangle_scan;

   localparam int W   = 40;
   localparam int H   = 50;
   localparam int CWB = 12;

   logic           Clock = 1'b0;
   logic           Reset_n = 1'b0;
   logic           tri_valid = 1'b0;
   logic           tri_ready;
   logic [CWB-1:0] Ponto1X = '0, Ponto1Y = '0, Ponto2X = '0;
   logic [CWB-1:0] Ponto2Y = '0, Ponto3X = '0, Ponto3Y = '0;
   logic [CWB-1:0] V1X, V1Y, V2X, V2Y, V3X, V3Y;
   logic           pt_valid;
   logic           pt_ready = 1'b0;
   logic [CWB-1:0] pt_x, pt_y;
   logic           pt_last;
   logic           tri_done;

   triangle_scan #(.SCREEN_W(W), .SCREEN_H(H), .CW(CWB)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .Ponto1X(Ponto1X), .Ponto1Y(Ponto1Y), .Ponto2X(Ponto2X), .Ponto2Y(Ponto2Y),
      .Ponto3X(Ponto3X), .Ponto3Y(Ponto3Y),
      .V1X(V1X), .V1Y(V1Y), .V2X(V2X), .V2Y(V2Y), .V3X(V3X), .V3Y(V3Y),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
      .pt_last(pt_last), .tri_done(tri_done)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int exp_x[$];
   int exp_y[$];

   typedef struct {
      int x1, y1, x2, y2, x3, y3;
      int n;
      int lx, ly;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected point list: every pixel of the screen-clipped bounding box, row-major.
   task automatic model(input int x1, y1, x2, y2, x3, y3);
      int xlo, xhi, ylo, yhi;
      exp_x.delete();
      exp_y.delete();
      xlo = x1; if (x2 < xlo) xlo = x2; if (x3 < xlo) xlo = x3;
      xhi = x1; if (x2 > xhi) xhi = x2; if (x3 > xhi) xhi = x3;
      ylo = y1; if (y2 < ylo) ylo = y2; if (y3 < ylo) ylo = y3;
      yhi = y1; if (y2 > yhi) yhi = y2; if (y3 > yhi) yhi = y3;
      if (xhi > W - 1) xhi = W - 1;
      if (yhi > H - 1) yhi = H - 1;
      for (int y = ylo; y <= yhi; y++)
         for (int x = xlo; x <= xhi; x++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
         end
   endtask

   task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input bit stall,
                          input int abort_after,
                          output int nseen, output int lastx, output int lasty);
      int n, guard, px, py, pl;
      bit held, fin, rdy;
      model(x1, y1, x2, y2, x3, y3);
      n = exp_x.size();
      nseen = 0; lastx = -1; lasty = -1;
      @(negedge Clock);
      guard = 0;
      while (!tri_ready && guard < 20) begin
         @(negedge Clock);
         guard++;
      end
      if (!tri_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      tri_valid = 1'b1; pt_ready = 1'b0;
      Ponto1X = 12'(x1); Ponto1Y = 12'(y1); Ponto2X = 12'(x2);
      Ponto2Y = 12'(y2); Ponto3X = 12'(x3); Ponto3Y = 12'(y3);
      @(negedge Clock);
      tri_valid = 1'b0;
      Ponto1X = 12'($urandom); Ponto2Y = 12'($urandom); Ponto3X = 12'($urandom);
      chk("v1x", int'(V1X), x1); chk("v1y", int'(V1Y), y1);
      chk("v2x", int'(V2X), x2); chk("v2y", int'(V2Y), y2);
      chk("v3x", int'(V3X), x3); chk("v3y", int'(V3Y), y3);
      chk("setup_valid", int'(pt_valid), 0);
      chk("setup_ready", int'(tri_ready), 0);
      @(negedge Clock);
      if (n == 0) begin
         chk("empty_valid", int'(pt_valid), 0);
         chk("empty_done", int'(tri_done), 1);
         @(negedge Clock);
         chk("empty_ready", int'(tri_ready), 1);
         chk("empty_done_low", int'(tri_done), 0);
         return;
      end
      chk("first_valid", int'(pt_valid), 1);
      chk("first_x", int'(pt_x), exp_x[0]);
      chk("first_y", int'(pt_y), exp_y[0]);
      held = 0; fin = 0; guard = 0; px = 0; py = 0; pl = 0;
      while (!fin && guard < 30 * n + 100) begin
         if (abort_after >= 0 && nseen == abort_after) begin
            Reset_n = 1'b0;
            pt_ready = 1'b0;
            #1;
            chk("rst_valid", int'(pt_valid), 0);
            chk("rst_last", int'(pt_last), 0);
            chk("rst_done", int'(tri_done), 0);
            chk("rst_ready", int'(tri_ready), 1);
            chk("rst_ptx", int'(pt_x), 0);
            chk("rst_pty", int'(pt_y), 0);
            chk("rst_v2x", int'(V2X), 0);
            @(negedge Clock);
            Reset_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge Clock);
               chk("rst_no_done", int'(tri_done), 0);
               chk("rst_no_valid", int'(pt_valid), 0);
            end
            return;
         end
         if (held) begin
            chk("hold_valid", int'(pt_valid), 1);
            chk("hold_x", int'(pt_x), px);
            chk("hold_y", int'(pt_y), py);
            chk("hold_last", int'(pt_last), pl);
         end
         if (!pt_valid) begin
            chk("valid_dropped", 0, 1);
            fin = 1;
         end else begin
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            pt_ready = rdy;
            if (rdy) begin
               if (nseen < n) begin
                  chk("pt_x", int'(pt_x), exp_x[nseen]);
                  chk("pt_y", int'(pt_y), exp_y[nseen]);
                  chk("pt_last", int'(pt_last), (nseen == n - 1) ? 1 : 0);
               end else begin
                  chk("extra_point", nseen, n - 1);
               end
               lastx = int'(pt_x); lasty = int'(pt_y);
               nseen++;
               held = 0;
               if (pt_last || nseen >= n) fin = 1;
            end else begin
               held = 1;
               px = int'(pt_x); py = int'(pt_y); pl = int'(pt_last);
            end
         end
         @(negedge Clock);
         guard++;
      end
      pt_ready = 1'b0;
      if (!fin) chk("scan_timeout", 0, 1);
      chk("count", nseen, n);
      chk("done_pulse", int'(tri_done), 1);
      chk("done_valid", int'(pt_valid), 0);
      @(negedge Clock);
      chk("done_low", int'(tri_done), 0);
      chk("idle_ready", int'(tri_ready), 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ns, lx, ly;
      int r[6];
      vecs[0] = '{10, 10, 10, 30, 30, 20, 441, 30, 30};
      vecs[1] = '{35, 45, 60, 45, 35, 70, 25, 39, 49};
      vecs[2] = '{45, 5, 50, 5, 45, 9, 0, -1, -1};
      vecs[3] = '{5, 5, 5, 5, 5, 5, 1, 5, 5};
      vecs[4] = '{39, 0, 39, 0, 39, 1, 2, 39, 1};
      vecs[5] = '{0, 49, 3, 49, 1, 60, 4, 3, 49};
      vecs[6] = '{12, 52, 3, 60, 7, 55, 0, -1, -1};

      repeat (3) @(negedge Clock);
      chk("reset_ready", int'(tri_ready), 1);
      chk("reset_valid", int'(pt_valid), 0);
      chk("reset_last", int'(pt_last), 0);
      chk("reset_done", int'(tri_done), 0);
      chk("reset_ptx", int'(pt_x), 0);
      chk("reset_v3y", int'(V3Y), 0);
      Reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_tri(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].x3, vecs[i].y3,
                 1'b0, -1, ns, lx, ly);
         chk("vec_count", ns, vecs[i].n);
         if (vecs[i].n > 0) begin
            chk("vec_last_x", lx, vecs[i].lx);
            chk("vec_last_y", ly, vecs[i].ly);
         end
      end

      run_tri(10, 10, 10, 30, 30, 20, 1'b1, -1, ns, lx, ly);
      chk("stall_count", ns, 441);

      run_tri(10, 10, 10, 30, 30, 20, 1'b0, 100, ns, lx, ly);
      chk("abort_count", ns, 100);
      run_tri(10, 10, 10, 30, 30, 20, 1'b0, -1, ns, lx, ly);
      chk("after_reset_count", ns, 441);

      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 6; k++) r[k] = int'($urandom_range(0, 63));
         run_tri(r[0], r[1], r[2], r[3], r[4], r[5], 1'(t % 2), -1, ns, lx, ly);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/triangle_scan.md
TRIANGLE_SCAN -- requirements
Module: triangle_scan

Interface
REQ-001 Parameter SCREEN_W, default 40: screen width in pixels; valid columns 0..SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 50: screen height in pixels; valid lines 0..SCREEN_H-1.
REQ-003 Parameter CW, default 12: coordinate width in bits; all coordinates unsigned.
REQ-004 Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 tri_valid  input  1  triangle descriptor present on Ponto* inputs.
REQ-007 tri_ready  output  1  block can accept a triangle this cycle.
REQ-008 Ponto1X, Ponto1Y, Ponto2X, Ponto2Y, Ponto3X, Ponto3Y  input  CW each  triangle vertices.
REQ-009 V1X, V1Y, V2X, V2Y, V3X, V3Y  output  CW each  registered copy of the accepted vertices, for the downstream inside-test.
REQ-010 pt_valid  output  1  test point on pt_x/pt_y is valid.
REQ-011 pt_ready  input  1  downstream inside-test accepts the point this cycle.
REQ-012 pt_x  output  CW  test column.
REQ-013 pt_y  output  CW  test line.
REQ-014 pt_last  output  1  current point is the final point of the triangle.
REQ-015 tri_done  output  1  one-cycle pulse: triangle fully scanned.

Function
REQ-016 Triangle accepted on any rising edge where tri_valid && tri_ready; vertices latched into V* at that edge.
REQ-017 State machine shall be IDLE -> SETUP -> SCAN -> DONE -> IDLE; tri_ready = 1 only in IDLE.
REQ-018 SETUP (exactly one cycle): xmin/xmax = min/max of the three X; ymin/ymax = min/max of the three Y; xmax clamped to SCREEN_W-1; ymax clamped to SCREEN_H-1.
REQ-019 Empty box: xmin > SCREEN_W-1 or ymin > SCREEN_H-1 -> SETUP goes directly to DONE; no pt_valid is issued.
REQ-020 SCAN order: row-major; y ascending ymin..ymax; within each row x ascending xmin..xmax.
REQ-021 First pt_valid is asserted 2 cycles after the accepting edge, with (xmin, ymin).
REQ-022 pt_x, pt_y and pt_last are held stable while pt_valid && !pt_ready; pt_valid never drops without a handshake.
REQ-023 On each handshake, the block advances to the next point in the following cycle; back-to-back handshakes yield one point per cycle.
REQ-024 pt_last = 1 exactly when pt_x == xmax && pt_y == ymax.
REQ-025 Handshake with pt_last -> DONE; tri_done = 1 in DONE for exactly one cycle; next cycle IDLE.
REQ-026 Points emitted per triangle = (xmax-xmin+1)*(ymax-ymin+1) after clamping; counters shall not wrap.
REQ-027 V* shall hold stable from acceptance until return to IDLE.
REQ-028 tri_valid outside IDLE is ignored; no queuing.

Reset
REQ-029 Reset_n low shall immediately force IDLE, and shall also force: tri_ready = 1 after release, pt_valid = 0, pt_last = 0, tri_done = 0, pt_x = pt_y = 0, V* = 0.
REQ-030 Reset mid-SCAN abandons the triangle; no tri_done is produced for it.

Structure
REQ-031 A shared package shall hold the state enumeration, CW, and the SCREEN_W/SCREEN_H defaults, shared with the inside-test and raster stages.
REQ-032 One sub-module, bbox3, shall be purely combinational and compute clamped min/max of three coordinates plus the empty flag; it is instantiated once per axis.

Verification
REQ-033 Triangle (10,10),(10,30),(30,20), pt_ready = 1 -> 441 points; first (10,10) at accept+2; last (30,30) with pt_last; tri_done one cycle later.
REQ-034 Same triangle, pt_ready toggled pseudo-randomly -> identical point sequence; no drops or duplicates; outputs stable while stalled.
REQ-035 Triangle (35,45),(60,45),(35,70) -> clamped box x 35..39, y 45..49; 25 points; last (39,49).
REQ-036 Triangle (45,5),(50,5),(45,9) -> zero pt_valid; tri_done at accept+2; tri_ready back at accept+3.
REQ-037 Degenerate (5,5) x3 -> single point (5,5) with pt_last = 1.
REQ-038 Reset_n pulsed low after 100 points of REQ-033 -> pt_valid drops immediately; no tri_done; next triangle scans correctly from its first point.
